branch_resolve_ctrl: RTL and testbench



---
 rtl/branch_resolve_ctrl.sv | 154 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution control: comparator operand select/forward, hazard stall,
// one-cycle PC redirect with IF flush, saturating branch statistics and a stall watchdog.
module branch_resolve_ctrl #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [2:0]       id_br_ctrl,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [PC_W-1:0]  id_rs_data,
  input  logic [PC_W-1:0]  id_rt_data,
  input  logic [PC_W-1:0]  id_pc,
  input  logic [PC_W-1:0]  id_offset,
  input  logic             ex_wr_en,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_wr_reg,
  input  logic             mem_wr_en,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_wr_reg,
  input  logic [PC_W-1:0]  mem_alu_result,
  input  logic             cmp_out,
  output logic [2:0]       cmp_ctrl,
  output logic [PC_W-1:0]  cmp_in1,
  output logic [PC_W-1:0]  cmp_in2,
  output logic             stall_if_id,
  output logic             flush_if,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count,
  output logic             stall_err
);

  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);

  localparam logic [CTRL_W-1:0] BR_NONE = 3'b000;
  localparam logic [CTRL_W-1:0] BR_BEQ  = 3'b001;
  localparam logic [CTRL_W-1:0] BR_BNE  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STALL    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t             state;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_cnt_inc;

  logic            br_active;
  logic            use_rt;
  logic            rs_ex_hit;
  logic            rs_mem_hit;
  logic            rt_ex_hit;
  logic            rt_mem_hit;
  logic            rs_haz;
  logic            rt_haz;
  logic            hazard;
  logic            resolve;
  logic [PC_W-1:0] rs_val;
  logic [PC_W-1:0] rt_val;
  logic [PC_W-1:0] br_target;

  // An EX producer stalls whether or not it is a load; the load flag only matters in MEM.
  logic unused_ex_mem_read;
  assign unused_ex_mem_read = ex_mem_read;

  assign br_active = id_valid && (id_br_ctrl != BR_NONE);
  assign use_rt    = (id_br_ctrl == BR_BEQ) || (id_br_ctrl == BR_BNE);

  // Producer matches; register 0 is hardwired and never hazards or forwards.
  assign rs_ex_hit  = ex_wr_en  && (ex_wr_reg  == id_rs) && (id_rs != 5'd0);
  assign rs_mem_hit = mem_wr_en && (mem_wr_reg == id_rs) && (id_rs != 5'd0);
  assign rt_ex_hit  = ex_wr_en  && (ex_wr_reg  == id_rt) && (id_rt != 5'd0);
  assign rt_mem_hit = mem_wr_en && (mem_wr_reg == id_rt) && (id_rt != 5'd0);

  assign rs_haz = rs_ex_hit || (rs_mem_hit && mem_mem_read);
  assign rt_haz = use_rt && (rt_ex_hit || (rt_mem_hit && mem_mem_read));
  assign hazard = rs_haz || rt_haz;

  assign rs_val = rs_mem_hit ? mem_alu_result : id_rs_data;
  assign rt_val = rt_mem_hit ? mem_alu_result : id_rt_data;

  assign cmp_ctrl    = br_active ? id_br_ctrl : BR_NONE;
  assign cmp_in1     = rs_val;
  assign cmp_in2     = use_rt ? rt_val : '0;
  assign stall_if_id = br_active && hazard && (state != S_REDIRECT);
  assign resolve     = br_active && !hazard && (state != S_REDIRECT);
  assign br_target   = id_pc + PC_W'(4) + id_offset;

  // Run length saturates at the watchdog threshold so it can never wrap back below it.
  assign stall_cnt_inc = (stall_cnt == STALL_W'(MAX_STALL)) ? stall_cnt
                                                            : stall_cnt + STALL_W'(1);

  // Sequencer with registered redirect/flush, statistics and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      stall_cnt      <= '0;
      redirect_valid <= 1'b0;
      flush_if       <= 1'b0;
      redirect_pc    <= '0;
      branch_count   <= '0;
      taken_count    <= '0;
      stall_err      <= 1'b0;
    end else begin
      case (state)
        S_REDIRECT: begin
          state          <= S_IDLE;
          redirect_valid <= 1'b0;
          flush_if       <= 1'b0;
        end
        S_IDLE, S_STALL: begin
          if (br_active && hazard) begin
            state     <= S_STALL;
            stall_cnt <= stall_cnt_inc;
            if (stall_cnt_inc == STALL_W'(MAX_STALL)) begin
              stall_err <= 1'b1;
            end
          end else begin
            stall_cnt <= '0;
            state     <= S_IDLE;
            if (resolve) begin
              if (branch_count != '1) begin
                branch_count <= branch_count + CNT_W'(1);
              end
              if (cmp_out) begin
                if (taken_count != '1) begin
                  taken_count <= taken_count + CNT_W'(1);
                end
                redirect_pc    <= br_target;
                redirect_valid <= 1'b1;
                flush_if       <= 1'b1;
                state          <= S_REDIRECT;
              end
            end
          end
        end
        default: begin
          state          <= S_IDLE;
          stall_cnt      <= '0;
          redirect_valid <= 1'b0;
          flush_if       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the branch resolution rules.
module tb_branch_resolve_ctrl;

  localparam int unsigned PC_W      = 32;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned MAX_STALL = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [2:0]       id_br_ctrl;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [PC_W-1:0]  id_rs_data;
  logic [PC_W-1:0]  id_rt_data;
  logic [PC_W-1:0]  id_pc;
  logic [PC_W-1:0]  id_offset;
  logic             ex_wr_en;
  logic             ex_mem_read;
  logic [4:0]       ex_wr_reg;
  logic             mem_wr_en;
  logic             mem_mem_read;
  logic [4:0]       mem_wr_reg;
  logic [PC_W-1:0]  mem_alu_result;
  logic             cmp_out;
  logic [2:0]       cmp_ctrl;
  logic [PC_W-1:0]  cmp_in1;
  logic [PC_W-1:0]  cmp_in2;
  logic             stall_if_id;
  logic             flush_if;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;
  logic             stall_err;

  int checks;
  int failures;

  branch_resolve_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_br_ctrl(id_br_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_pc(id_pc), .id_offset(id_offset), .ex_wr_en(ex_wr_en), .ex_mem_read(ex_mem_read),
    .ex_wr_reg(ex_wr_reg), .mem_wr_en(mem_wr_en), .mem_mem_read(mem_mem_read),
    .mem_wr_reg(mem_wr_reg), .mem_alu_result(mem_alu_result), .cmp_out(cmp_out),
    .cmp_ctrl(cmp_ctrl), .cmp_in1(cmp_in1), .cmp_in2(cmp_in2), .stall_if_id(stall_if_id),
    .flush_if(flush_if), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .taken_count(taken_count), .stall_err(stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs;
    id_valid = 1'b0; id_br_ctrl = 3'b000; id_rs = 5'd0; id_rt = 5'd0;
    id_rs_data = '0; id_rt_data = '0; id_pc = '0; id_offset = '0;
    ex_wr_en = 1'b0; ex_mem_read = 1'b0; ex_wr_reg = 5'd0;
    mem_wr_en = 1'b0; mem_mem_read = 1'b0; mem_wr_reg = 5'd0; mem_alu_result = '0;
    cmp_out = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Value of register r as seen in ID: the youngest in-flight writer decides; bit PC_W = unresolved.
  function automatic logic [PC_W:0] view(input logic [4:0] r, input logic [PC_W-1:0] rf);
    if (r == 5'd0) return {1'b0, rf};
    if (ex_wr_en && ex_wr_reg == r) return {1'b1, rf};
    if (mem_wr_en && mem_wr_reg == r) return mem_mem_read ? {1'b1, rf} : {1'b0, mem_alu_result};
    return {1'b0, rf};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    #3;
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL rst_rv got=%0h exp=0", redirect_valid); end
    checks++; if (flush_if !== 1'b0) begin failures++; $display("FAIL rst_flush got=%0h exp=0", flush_if); end
    checks++; if (redirect_pc !== '0) begin failures++; $display("FAIL rst_pc got=%0h exp=0", redirect_pc); end
    checks++; if (branch_count !== '0) begin failures++; $display("FAIL rst_bc got=%0h exp=0", branch_count); end
    checks++; if (taken_count !== '0) begin failures++; $display("FAIL rst_tc got=%0h exp=0", taken_count); end
    checks++; if (stall_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", stall_err); end
    checks++; if (cmp_ctrl !== 3'b000) begin failures++; $display("FAIL rst_ctrl got=%0h exp=0", cmp_ctrl); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forward;
    do_reset();
    id_valid = 1'b1; id_br_ctrl = 3'b001; id_rs = 5'd3; id_rt = 5'd4;
    id_rs_data = 32'd5; id_rt_data = 32'd9; id_pc = 32'h100; id_offset = 32'h20;
    mem_wr_en = 1'b1; mem_wr_reg = 5'd4; mem_alu_result = 32'd5; cmp_out = 1'b1;
    #1;
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL fwd_stall got=%0h exp=0", stall_if_id); end
    checks++; if (cmp_ctrl !== 3'b001) begin failures++; $display("FAIL fwd_ctrl got=%0h exp=1", cmp_ctrl); end
    checks++; if (cmp_in1 !== 32'd5) begin failures++; $display("FAIL fwd_in1 got=%0h exp=5", cmp_in1); end
    checks++; if (cmp_in2 !== 32'd5) begin failures++; $display("FAIL fwd_in2 got=%0h exp=5", cmp_in2); end
    tick();
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL fwd_rv got=%0h exp=1", redirect_valid); end
    checks++; if (flush_if !== 1'b1) begin failures++; $display("FAIL fwd_flush got=%0h exp=1", flush_if); end
    checks++; if (redirect_pc !== 32'h124) begin failures++; $display("FAIL fwd_pc got=%0h exp=124", redirect_pc); end
    checks++; if (branch_count !== CNT_W'(1)) begin failures++; $display("FAIL fwd_bc got=%0h exp=1", branch_count); end
    checks++; if (taken_count !== CNT_W'(1)) begin failures++; $display("FAIL fwd_tc got=%0h exp=1", taken_count); end
    // Same branch still in ID during the redirect cycle: no stall, no second count.
    ex_wr_en = 1'b1; ex_wr_reg = 5'd3;
    #1;
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL redir_stall got=%0h exp=0", stall_if_id); end
    tick();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL redir_rv_drop got=%0h exp=0", redirect_valid); end
    checks++; if (flush_if !== 1'b0) begin failures++; $display("FAIL redir_flush_drop got=%0h exp=0", flush_if); end
    checks++; if (branch_count !== CNT_W'(1)) begin failures++; $display("FAIL redir_bc got=%0h exp=1", branch_count); end
  endtask

  task automatic test_load_use;
    do_reset();
    id_valid = 1'b1; id_br_ctrl = 3'b010; id_rs = 5'd2; id_rt = 5'd5;
    id_rs_data = 32'h11; id_rt_data = 32'h77; id_pc = 32'h400; id_offset = 32'h40;
    ex_wr_en = 1'b1; ex_mem_read = 1'b1; ex_wr_reg = 5'd2; cmp_out = 1'b0;
    #1;
    checks++; if (stall_if_id !== 1'b1) begin failures++; $display("FAIL lu_stall_ex got=%0h exp=1", stall_if_id); end
    tick();
    checks++; if (branch_count !== '0) begin failures++; $display("FAIL lu_bc_ex got=%0h exp=0", branch_count); end
    ex_wr_en = 1'b0; ex_mem_read = 1'b0;
    mem_wr_en = 1'b1; mem_mem_read = 1'b1; mem_wr_reg = 5'd2;
    #1;
    checks++; if (stall_if_id !== 1'b1) begin failures++; $display("FAIL lu_stall_mem got=%0h exp=1", stall_if_id); end
    tick();
    mem_wr_en = 1'b0; mem_mem_read = 1'b0; id_rs_data = 32'h77;
    #1;
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL lu_stall_wb got=%0h exp=0", stall_if_id); end
    checks++; if (cmp_in1 !== 32'h77) begin failures++; $display("FAIL lu_in1 got=%0h exp=77", cmp_in1); end
    checks++; if (cmp_ctrl !== 3'b010) begin failures++; $display("FAIL lu_ctrl got=%0h exp=2", cmp_ctrl); end
    tick();
    checks++; if (branch_count !== CNT_W'(1)) begin failures++; $display("FAIL lu_bc got=%0h exp=1", branch_count); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL lu_rv got=%0h exp=0", redirect_valid); end
    id_valid = 1'b0;
    tick();
    checks++; if (branch_count !== CNT_W'(1)) begin failures++; $display("FAIL lu_bc_once got=%0h exp=1", branch_count); end
  endtask

  task automatic test_single_operand;
    do_reset();
    id_valid = 1'b1; id_br_ctrl = 3'b101; id_rs = 5'd7; id_rs_data = 32'hFFFF_FFF0;
    id_rt = 5'd9; id_rt_data = 32'h1234; ex_wr_en = 1'b1; ex_wr_reg = 5'd9;
    id_pc = 32'h200; id_offset = 32'hFFFF_FFF0; cmp_out = 1'b1;
    #1;
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL bltz_stall got=%0h exp=0", stall_if_id); end
    checks++; if (cmp_ctrl !== 3'b101) begin failures++; $display("FAIL bltz_ctrl got=%0h exp=5", cmp_ctrl); end
    checks++; if (cmp_in1 !== 32'hFFFF_FFF0) begin failures++; $display("FAIL bltz_in1 got=%0h exp=fffffff0", cmp_in1); end
    checks++; if (cmp_in2 !== 32'h0) begin failures++; $display("FAIL bltz_in2 got=%0h exp=0", cmp_in2); end
    tick();
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL bltz_rv got=%0h exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h1F4) begin failures++; $display("FAIL bltz_pc got=%0h exp=1f4", redirect_pc); end
    clear_inputs();
    tick();
    id_valid = 1'b1; id_br_ctrl = 3'b100; id_rs = 5'd7; id_rs_data = 32'h0;
    id_rt = 5'd7; id_rt_data = 32'hABCD; cmp_out = 1'b0;
    #1;
    checks++; if (cmp_ctrl !== 3'b100) begin failures++; $display("FAIL bgtz_ctrl got=%0h exp=4", cmp_ctrl); end
    checks++; if (cmp_in2 !== 32'h0) begin failures++; $display("FAIL bgtz_in2 got=%0h exp=0", cmp_in2); end
    tick();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL bgtz_rv got=%0h exp=0", redirect_valid); end
    checks++; if (branch_count !== CNT_W'(2)) begin failures++; $display("FAIL bgtz_bc got=%0h exp=2", branch_count); end
    checks++; if (taken_count !== CNT_W'(1)) begin failures++; $display("FAIL bgtz_tc got=%0h exp=1", taken_count); end
  endtask

  task automatic test_r0;
    do_reset();
    id_valid = 1'b1; id_br_ctrl = 3'b001; id_pc = 32'h40; id_offset = 32'h8;
    ex_wr_en = 1'b1; ex_wr_reg = 5'd0;
    mem_wr_en = 1'b1; mem_wr_reg = 5'd0; mem_alu_result = 32'hDEAD; cmp_out = 1'b1;
    #1;
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL r0_stall got=%0h exp=0", stall_if_id); end
    checks++; if (cmp_in1 !== 32'h0) begin failures++; $display("FAIL r0_in1 got=%0h exp=0", cmp_in1); end
    checks++; if (cmp_in2 !== 32'h0) begin failures++; $display("FAIL r0_in2 got=%0h exp=0", cmp_in2); end
    tick();
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL r0_rv got=%0h exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h4C) begin failures++; $display("FAIL r0_pc got=%0h exp=4c", redirect_pc); end
    checks++; if (branch_count !== CNT_W'(1)) begin failures++; $display("FAIL r0_bc got=%0h exp=1", branch_count); end
    clear_inputs();
    tick();
    id_br_ctrl = 3'b001; id_rs = 5'd3; ex_wr_en = 1'b1; ex_wr_reg = 5'd3;
    #1;
    checks++; if (cmp_ctrl !== 3'b000) begin failures++; $display("FAIL inact_ctrl got=%0h exp=0", cmp_ctrl); end
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL inact_stall got=%0h exp=0", stall_if_id); end
  endtask

  task automatic test_watchdog;
    do_reset();
    id_valid = 1'b1; id_br_ctrl = 3'b001; id_rs = 5'd6; id_rt = 5'd1;
    ex_wr_en = 1'b1; ex_wr_reg = 5'd6;
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++; if (stall_if_id !== 1'b1) begin failures++; $display("FAIL wd_stall k=%0d got=%0h exp=1", k, stall_if_id); end
      tick();
      checks++;
      if (stall_err !== (k >= MAX_STALL)) begin
        failures++; $display("FAIL wd_err k=%0d got=%0h exp=%0h", k, stall_err, (k >= MAX_STALL));
      end
    end
    id_valid = 1'b0;
    tick();
    checks++; if (stall_err !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%0h exp=1", stall_err); end
    checks++; if (branch_count !== '0) begin failures++; $display("FAIL wd_bc got=%0h exp=0", branch_count); end
    id_valid = 1'b1; ex_wr_en = 1'b0; cmp_out = 1'b0;
    tick();
    checks++; if (branch_count !== CNT_W'(1)) begin failures++; $display("FAIL wd_resolve_bc got=%0h exp=1", branch_count); end
    checks++; if (stall_err !== 1'b1) begin failures++; $display("FAIL wd_sticky2 got=%0h exp=1", stall_err); end
  endtask

  task automatic test_random;
    logic [PC_W:0]   vs;
    logic [PC_W:0]   vt;
    logic            act;
    logic            haz;
    bit              m_redir;
    bit              m_err;
    int              m_run;
    int              m_bc;
    int              m_tc;
    logic [PC_W-1:0] m_pc;
    do_reset();
    m_redir = 0; m_err = 0; m_run = 0; m_bc = 0; m_tc = 0; m_pc = '0;
    for (int n = 0; n < 600; n++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_br_ctrl = 3'($urandom_range(0, 5));
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rs_data = $urandom; id_rt_data = $urandom; id_pc = $urandom; id_offset = $urandom;
      ex_wr_en = 1'($urandom_range(0, 1)); ex_mem_read = 1'($urandom_range(0, 1));
      ex_wr_reg = 5'($urandom_range(0, 5));
      mem_wr_en = 1'($urandom_range(0, 1)); mem_mem_read = 1'($urandom_range(0, 1));
      mem_wr_reg = 5'($urandom_range(0, 5)); mem_alu_result = $urandom;
      cmp_out = 1'($urandom_range(0, 1));
      act = id_valid && (id_br_ctrl != 3'b000);
      vs = view(id_rs, id_rs_data);
      vt = (id_br_ctrl == 3'b001 || id_br_ctrl == 3'b010) ? view(id_rt, id_rt_data) : '0;
      haz = vs[PC_W] | vt[PC_W];
      #1;
      checks++; if (cmp_ctrl !== (act ? id_br_ctrl : 3'b000)) begin failures++; $display("FAIL rnd_ctrl n=%0d got=%0h exp=%0h", n, cmp_ctrl, (act ? id_br_ctrl : 3'b000)); end
      checks++; if (stall_if_id !== (act && haz && !m_redir)) begin failures++; $display("FAIL rnd_stall n=%0d got=%0h exp=%0h", n, stall_if_id, (act && haz && !m_redir)); end
      if (act && !haz) begin
        checks++; if (cmp_in1 !== vs[PC_W-1:0]) begin failures++; $display("FAIL rnd_in1 n=%0d got=%0h exp=%0h", n, cmp_in1, vs[PC_W-1:0]); end
        checks++; if (cmp_in2 !== vt[PC_W-1:0]) begin failures++; $display("FAIL rnd_in2 n=%0d got=%0h exp=%0h", n, cmp_in2, vt[PC_W-1:0]); end
      end
      if (m_redir) begin
        m_redir = 0;
      end else if (act && haz) begin
        m_run++;
        if (m_run >= MAX_STALL) m_err = 1;
      end else begin
        m_run = 0;
        if (act) begin
          if (m_bc < CNT_MAX) m_bc++;
          if (cmp_out) begin
            if (m_tc < CNT_MAX) m_tc++;
            m_pc = id_pc + PC_W'(4) + id_offset;
            m_redir = 1;
          end
        end
      end
      tick();
      checks++; if (redirect_valid !== m_redir) begin failures++; $display("FAIL rnd_rv n=%0d got=%0h exp=%0h", n, redirect_valid, m_redir); end
      checks++; if (flush_if !== m_redir) begin failures++; $display("FAIL rnd_flush n=%0d got=%0h exp=%0h", n, flush_if, m_redir); end
      checks++; if (redirect_pc !== m_pc) begin failures++; $display("FAIL rnd_pc n=%0d got=%0h exp=%0h", n, redirect_pc, m_pc); end
      checks++; if (branch_count !== CNT_W'(m_bc)) begin failures++; $display("FAIL rnd_bc n=%0d got=%0h exp=%0h", n, branch_count, m_bc); end
      checks++; if (taken_count !== CNT_W'(m_tc)) begin failures++; $display("FAIL rnd_tc n=%0d got=%0h exp=%0h", n, taken_count, m_tc); end
      checks++; if (stall_err !== m_err) begin failures++; $display("FAIL rnd_err n=%0d got=%0h exp=%0h", n, stall_err, m_err); end
    end
  endtask

  task automatic test_saturation;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      id_valid = 1'b1; id_br_ctrl = 3'b001; id_rs = 5'd1; id_rt = 5'd2; cmp_out = 1'b1;
      tick();
      id_valid = 1'b0;
      tick();
      if (i == 253) begin
        checks++; if (branch_count !== CNT_W'(254)) begin failures++; $display("FAIL sat_bc_pre got=%0h exp=fe", branch_count); end
      end
    end
    checks++; if (branch_count !== CNT_W'(CNT_MAX)) begin failures++; $display("FAIL sat_bc got=%0h exp=ff", branch_count); end
    checks++; if (taken_count !== CNT_W'(CNT_MAX)) begin failures++; $display("FAIL sat_tc got=%0h exp=ff", taken_count); end
    id_valid = 1'b1; cmp_out = 1'b0;
    tick();
    checks++; if (branch_count !== CNT_W'(CNT_MAX)) begin failures++; $display("FAIL sat_bc_nt got=%0h exp=ff", branch_count); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    id_valid = 1'b1; id_br_ctrl = 3'b001; id_rs = 5'd1; id_rt = 5'd2;
    id_pc = 32'h300; id_offset = 32'h4; cmp_out = 1'b1;
    tick();
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_rv got=%0h exp=1", redirect_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL mid_rv got=%0h exp=0", redirect_valid); end
    checks++; if (flush_if !== 1'b0) begin failures++; $display("FAIL mid_flush got=%0h exp=0", flush_if); end
    checks++; if (branch_count !== '0) begin failures++; $display("FAIL mid_bc got=%0h exp=0", branch_count); end
    checks++; if (taken_count !== '0) begin failures++; $display("FAIL mid_tc got=%0h exp=0", taken_count); end
    checks++; if (redirect_pc !== '0) begin failures++; $display("FAIL mid_pc got=%0h exp=0", redirect_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (stall_if_id !== 1'b0) begin failures++; $display("FAIL mid_post_stall got=%0h exp=0", stall_if_id); end
    tick();
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL mid_post_rv got=%0h exp=1", redirect_valid); end
    checks++; if (branch_count !== CNT_W'(1)) begin failures++; $display("FAIL mid_post_bc got=%0h exp=1", branch_count); end
    checks++; if (redirect_pc !== 32'h308) begin failures++; $display("FAIL mid_post_pc got=%0h exp=308", redirect_pc); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_single_operand();
    test_r0();
    test_watchdog();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
